// File: rtl/sysray_drain.sv
// sysray_drain: re-aligns column-staggered bottom-row psums of the systolic array
// into complete rows and buffers them in a FIFO behind a valid/ready interface.
`default_nettype none

module sysray_drain #(
  parameter int N      = 2,
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PSUM_W-1:0]            psum_i       [N],
  input  logic [N-1:0]                 psum_valid_i,
  output logic [PSUM_W-1:0]            row_o        [N],
  output logic                         row_valid_o,
  input  logic                         row_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic                         skew_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PSUM_W-1:0] dsk_data [N];
  logic [N-1:0]      dsk_valid;

  // Column j waits N-1-j cycles so every column of a row lines up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int STG = N - 1 - j;
    if (STG == 0) begin : g_pass
      assign dsk_data[j]  = psum_i[j];
      assign dsk_valid[j] = psum_valid_i[j];
    end else begin : g_dly
      logic [PSUM_W-1:0] sd [STG];
      logic [STG-1:0]    sv;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < STG; k++) sd[k] <= '0;
          sv <= '0;
        end else begin
          sd[0] <= psum_i[j];
          sv[0] <= psum_valid_i[j];
          for (int k = 1; k < STG; k++) begin
            sd[k] <= sd[k-1];
            sv[k] <= sv[k-1];
          end
        end
      end
      assign dsk_data[j]  = sd[STG-1];
      assign dsk_valid[j] = sv[STG-1];
    end
  end

  logic [PSUM_W-1:0] mem [DEPTH][N];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              all_v;
  logic              any_v;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign all_v = &dsk_valid;
  assign any_v = |dsk_valid;
  assign full  = (count == CW'(DEPTH));
  assign pop   = (count != '0) && row_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the row.
  assign push  = all_v && (!full || pop);
  assign drop  = all_v && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      skew_err_o <= 1'b0;
      for (int d = 0; d < DEPTH; d++)
        for (int c = 0; c < N; c++) mem[d][c] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dsk_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow_o <= 1'b1;
      if (any_v && !all_v) skew_err_o <= 1'b1;
    end
  end

  assign row_o       = mem[rd_ptr];
  assign row_valid_o = (count != '0);
  assign count_o     = count;

endmodule

`default_nettype wire
